// File: rtl/load_store_unit.sv
// Package and memory-stage load/store unit for the RV32I pipeline.
// One load or store at a time is turned into a single data-memory
// transaction. Loads come back aligned and sign- or zero-extended.

package mem_interface_pkg;

  // Request to data memory.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  // Response from data memory.
  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
  } mem_resp_t;

  // FSM state of the load/store unit, also visible on its debug port.
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

endpackage

// Handshakes:
//   op:   an operation is taken on a rising edge where op_valid_i && op_ready_o.
//         op_ready_o is high only in IDLE, and op_* is ignored at all other times.
//   req:  mem_req_o.valid stays high and every request field stays frozen until
//         a rising edge samples mem_resp_i.ready high. That edge completes the
//         request.
//   resp: mem_resp_i.rvalid is taken only in WAIT. At any other time it is
//         dropped, so stray or post-reset responses have no effect.
module load_store_unit
  import mem_interface_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic        op_we_i,
  input  logic [2:0]  op_funct3_i,
  input  logic [31:0] op_addr_i,
  input  logic [31:0] op_wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output mem_req_t    mem_req_o,
  input  mem_resp_t   mem_resp_i,
  output lsu_state_e  dbg_state_o
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_d;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_legal;
  logic        w_accept;
  logic        w_done_d;
  logic        w_err_d;
  logic        w_load_done;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  // Legality of the presented operation: funct3 must be defined for the
  // direction, and the address must be aligned to the access size.
  always_comb begin
    w_legal = 1'b0;
    case (op_funct3_i)
      3'b000:  w_legal = 1'b1;
      3'b001:  w_legal = (op_addr_i[0] == 1'b0);
      3'b010:  w_legal = (op_addr_i[1:0] == 2'b00);
      3'b100:  w_legal = !op_we_i;
      3'b101:  w_legal = !op_we_i && (op_addr_i[0] == 1'b0);
      default: w_legal = 1'b0;
    endcase
  end

  // Store byte enables and lane-replicated write data, captured at acceptance.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = op_wdata_i;
    case (op_funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << op_addr_i[1:0];
        w_wdata = {4{op_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = op_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{op_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = op_wdata_i;
      end
    endcase
  end

  // Load lane selection and extension from the latched address and funct3.
  always_comb begin
    w_lane_shift = mem_resp_i.rdata >> {r_addr[1:0], 3'b000};
    w_byte       = w_lane_shift[7:0];
    w_half       = r_addr[1] ? mem_resp_i.rdata[31:16] : mem_resp_i.rdata[15:0];
    w_load_fmt   = mem_resp_i.rdata;
    case (r_funct3)
      3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_fmt = {24'd0, w_byte};
      3'b101:  w_load_fmt = {16'd0, w_half};
      default: w_load_fmt = mem_resp_i.rdata;
    endcase
  end

  // Next state, acceptance and completion decisions.
  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_done_d    = 1'b0;
    w_err_d     = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        if (op_valid_i) begin
          if (w_legal) begin
            w_accept  = 1'b1;
            w_state_d = LSU_REQ;
          end else begin
            // Rejected without touching memory; reported next cycle.
            w_done_d = 1'b1;
            w_err_d  = 1'b1;
          end
        end
      end
      LSU_REQ: begin
        if (mem_resp_i.ready) begin
          if (r_we) begin
            w_state_d = LSU_IDLE;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        if (mem_resp_i.rvalid) begin
          w_state_d   = LSU_IDLE;
          w_done_d    = 1'b1;
          w_load_done = 1'b1;
        end
      end
      default: w_state_d = LSU_IDLE;
    endcase
  end

  // State, latched operation and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= LSU_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      if (w_accept) begin
        r_we     <= op_we_i;
        r_funct3 <= op_funct3_i;
        r_addr   <= op_addr_i;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
      end
      if (w_load_done) begin
        r_rdata <= w_load_fmt;
      end
    end
  end

  // Request is built only from state and latched registers. All fields are
  // zero outside REQ.
  always_comb begin
    mem_req_o = '0;
    if (r_state == LSU_REQ) begin
      mem_req_o.valid = 1'b1;
      mem_req_o.we    = r_we;
      mem_req_o.addr  = {r_addr[31:2], 2'b00};
      mem_req_o.be    = r_be;
      mem_req_o.wdata = r_wdata;
    end
  end

  assign op_ready_o  = (r_state == LSU_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. Inputs are driven and outputs are
// sampled on the falling edge of the clock. Expected results come from a
// byte-lane model of memory accesses.
module tb_load_store_unit;
  import mem_interface_pkg::*;

  logic        clk;
  logic        rst;
  logic        op_valid_i;
  logic        op_ready_o;
  logic        op_we_i;
  logic [2:0]  op_funct3_i;
  logic [31:0] op_addr_i;
  logic [31:0] op_wdata_i;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  mem_req_t    mem_req_o;
  mem_resp_t   mem_resp_i;
  lsu_state_e  dbg_state_o;

  int          checks;
  int          failures;
  logic [31:0] exp_rdata;

  load_store_unit dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_we_i     (op_we_i),
    .op_funct3_i (op_funct3_i),
    .op_addr_i   (op_addr_i),
    .op_wdata_i  (op_wdata_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_resp_i  (mem_resp_i),
    .dbg_state_o (dbg_state_o)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one operation from a falling edge with op_ready_o expected high.
  // Returns on the falling edge where done_o is expected, so consecutive
  // calls are back-to-back. rdly is the number of cycles ready is held low.
  // vdly is the number of WAIT cycles before rvalid.
  task automatic do_op(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rdly, input int vdly, input logic [31:0] rd);
    int          size;
    int          off;
    logic        legal;
    logic [7:0]  wb[4];
    logic [7:0]  rb[4];
    logic [3:0]  ebe;
    logic [31:0] ewd;
    longint      v;
    mem_req_t    ereq;

    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    if (we) legal = (f3 inside {3'd0, 3'd1, 3'd2});
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    legal = legal && ((off % size) == 0);

    for (int l = 0; l < 4; l++) begin
      wb[l] = wd[8*l +: 8];
      rb[l] = rd[8*l +: 8];
    end
    for (int l = 0; l < 4; l++) begin
      ebe[l]        = (l >= off) && (l < off + size);
      ewd[8*l +: 8] = wb[l % size];
    end
    ereq.valid = 1'b1;
    ereq.we    = we;
    ereq.addr  = {addr[31:2], 2'b00};
    ereq.be    = ebe;
    ereq.wdata = ewd;

    checks++;
    if (op_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL op_ready_before_op: got %b want 1", op_ready_o);
    end
    op_valid_i  = 1'b1;
    op_we_i     = we;
    op_funct3_i = f3;
    op_addr_i   = addr;
    op_wdata_i  = wd;
    @(negedge clk);
    op_valid_i  = 1'b0;
    op_we_i     = 1'($urandom);
    op_funct3_i = 3'($urandom);
    op_addr_i   = $urandom;
    op_wdata_i  = $urandom;

    if (!legal) begin
      checks++;
      if (done_o !== 1'b1 || err_o !== 1'b1 || mem_req_o.valid !== 1'b0) begin
        failures++;
        $display("FAIL illegal_resp: done=%b err=%b valid=%b want 1 1 0",
                 done_o, err_o, mem_req_o.valid);
      end
      checks++;
      if (rdata_o !== exp_rdata) begin
        failures++;
        $display("FAIL rdata_hold_illegal: got %h want %h", rdata_o, exp_rdata);
      end
      return;
    end

    for (int c = 0; c <= rdly; c++) begin
      checks++;
      if (mem_req_o !== ereq) begin
        failures++;
        $display("FAIL req_fields c=%0d: got %h want %h", c, mem_req_o, ereq);
      end
      checks++;
      if (op_ready_o !== 1'b0 || done_o !== 1'b0) begin
        failures++;
        $display("FAIL req_busy: ready=%b done=%b want 0 0", op_ready_o, done_o);
      end
      mem_resp_i.ready = (c == rdly);
      @(negedge clk);
    end
    mem_resp_i.ready = 1'b0;

    if (we) begin
      checks++;
      if (done_o !== 1'b1 || err_o !== 1'b0 || mem_req_o.valid !== 1'b0) begin
        failures++;
        $display("FAIL store_done: done=%b err=%b valid=%b want 1 0 0",
                 done_o, err_o, mem_req_o.valid);
      end
      checks++;
      if (rdata_o !== exp_rdata) begin
        failures++;
        $display("FAIL rdata_hold_store: got %h want %h", rdata_o, exp_rdata);
      end
      return;
    end

    v = 0;
    for (int k = 0; k < size; k++) v = v | (longint'(rb[off + k]) << (8 * k));
    if (!f3[2] && size < 4 && ((v >> (8 * size - 1)) & 1) == 1)
      v = v - (longint'(1) << (8 * size));
    exp_rdata = v[31:0];

    for (int c = 0; c <= vdly; c++) begin
      checks++;
      if (mem_req_o.valid !== 1'b0 || done_o !== 1'b0 || op_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL wait_state c=%0d: valid=%b done=%b ready=%b want 0 0 0",
                 c, mem_req_o.valid, done_o, op_ready_o);
      end
      mem_resp_i.rvalid = (c == vdly);
      mem_resp_i.rdata  = (c == vdly) ? rd : $urandom;
      @(negedge clk);
    end
    mem_resp_i.rvalid = 1'b0;
    checks++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL load_done: done=%b err=%b want 1 0", done_o, err_o);
    end
    checks++;
    if (rdata_o !== exp_rdata) begin
      failures++;
      $display("FAIL load_rdata f3=%0d addr=%h: got %h want %h",
               f3, addr, rdata_o, exp_rdata);
    end
  endtask

  // Idle cycles with random stray ready/rvalid. Nothing may change.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_resp_i.ready  = 1'($urandom);
      mem_resp_i.rvalid = 1'($urandom);
      mem_resp_i.rdata  = $urandom;
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0 || rdata_o !== exp_rdata || mem_req_o !== '0 ||
          dbg_state_o !== LSU_IDLE) begin
        failures++;
        $display("FAIL idle_stray: done=%b rdata=%h req=%h state=%0d want 0 %h 0 idle",
                 done_o, rdata_o, mem_req_o, dbg_state_o, exp_rdata);
      end
    end
    mem_resp_i = '0;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    op_valid_i = 1'b0; op_we_i = 1'b0; op_funct3_i = 3'd0;
    op_addr_i  = 32'd0; op_wdata_i = 32'd0;
    mem_resp_i = '0;
    exp_rdata  = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done_o !== 1'b0 || err_o !== 1'b0 || rdata_o !== 32'd0 ||
        mem_req_o !== '0 || op_ready_o !== 1'b1 || dbg_state_o !== LSU_IDLE) begin
      failures++;
      $display("FAIL reset_state: done=%b err=%b rdata=%h req=%h ready=%b",
               done_o, err_o, rdata_o, mem_req_o, op_ready_o);
    end
  endtask

  task automatic test_store_sb;
    do_op(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'd0);
    do_op(1'b1, 3'b001, 32'h0000_2002, 32'h1234_5678, 1, 0, 32'd0);
    idle_cycles(2);
  endtask

  task automatic test_loads;
    do_op(1'b0, 3'b000, 32'h0000_4002, 32'd0, 0, 0, 32'h1280_3456);
    do_op(1'b0, 3'b100, 32'h0000_4002, 32'd0, 0, 0, 32'h1280_3456);
    do_op(1'b0, 3'b101, 32'h0000_4002, 32'd0, 0, 2, 32'h1280_3456);
    do_op(1'b0, 3'b001, 32'h0000_4000, 32'd0, 0, 1, 32'h1280_F456);
    do_op(1'b0, 3'b010, 32'h0000_4004, 32'd0, 2, 0, 32'hCAFE_BABE);
    idle_cycles(2);
  endtask

  task automatic test_illegal;
    do_op(1'b0, 3'b010, 32'h0000_5001, 32'd0, 0, 0, 32'd0);
    do_op(1'b0, 3'b011, 32'h0000_5000, 32'd0, 0, 0, 32'd0);
    do_op(1'b1, 3'b100, 32'h0000_5000, 32'h1111_2222, 0, 0, 32'd0);
    do_op(1'b1, 3'b001, 32'h0000_5003, 32'h1111_2222, 0, 0, 32'd0);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back;
    // SW stalled 3 cycles, then an LBU taken in the same cycle done_o is high.
    do_op(1'b1, 3'b010, 32'h0000_6008, 32'h0BAD_F00D, 3, 0, 32'd0);
    do_op(1'b0, 3'b100, 32'h0000_6003, 32'd0, 0, 0, 32'h9ABC_DEF0);
    do_op(1'b0, 3'b011, 32'h0000_6000, 32'd0, 0, 0, 32'd0);
    do_op(1'b1, 3'b000, 32'h0000_6001, 32'h0000_00EE, 0, 0, 32'd0);
    idle_cycles(2);
  endtask

  task automatic test_reset_in_wait;
    op_valid_i = 1'b1; op_we_i = 1'b0; op_funct3_i = 3'b010;
    op_addr_i = 32'h0000_7000; op_wdata_i = 32'd0;
    @(negedge clk);
    op_valid_i = 1'b0;
    mem_resp_i.ready = 1'b1;
    @(negedge clk);
    mem_resp_i.ready = 1'b0;
    checks++;
    if (dbg_state_o !== LSU_WAIT || op_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reach_wait: state=%0d ready=%b want wait 0", dbg_state_o, op_ready_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'd0;
    mem_resp_i.rvalid = 1'b1;
    mem_resp_i.rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_resp_i = '0;
    checks++;
    if (done_o !== 1'b0 || rdata_o !== 32'd0 || op_ready_o !== 1'b1 ||
        dbg_state_o !== LSU_IDLE || mem_req_o !== '0) begin
      failures++;
      $display("FAIL late_rvalid: done=%b rdata=%h ready=%b state=%0d want 0 0 1 idle",
               done_o, rdata_o, op_ready_o, dbg_state_o);
    end
    idle_cycles(2);
  endtask

  task automatic test_random;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        else if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      do_op(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_store_sb;
    test_loads;
    test_illegal;
    test_back_to_back;
    test_reset_in_wait;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
